// File: rtl/sp_ram_ext.sv
// sp_ram_ext: single-port byte-lane RAM with selectable read latency, read-during-write mode and clear-on-reset
module sp_ram_ext #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int BYTE_WIDTH     = 8,
   parameter int RD_LATENCY     = 1,
   parameter int WR_MODE        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                               clka,
   input  logic                               rsta,
   input  logic                               ena,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea,
   input  logic [ADDR_WIDTH-1:0]              addra,
   input  logic [DATA_WIDTH-1:0]              dina,
   output logic [DATA_WIDTH-1:0]              douta,
   output logic                               douta_vld,
   output logic                               busy
);
   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t                state;
   logic [ADDR_WIDTH:0]   cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] old, merged, d1, d2;
   logic                  v1, v2, acc, wr, take;
   assign busy  = state == CLEAR;
   assign acc   = ena && !busy;
   assign wr    = |wea;
   assign take  = acc && !(wr && WR_MODE == 2);
   assign old   = mem[addra];
   always_comb begin
      merged = old;
      for (int i = 0; i < NB; i++)
         if (wea[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
   end
   always_ff @(posedge clka)
      if (rsta) begin
         state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
         cnt   <= '0;
      end else if (busy) begin
         cnt <= cnt + (ADDR_WIDTH+1)'(1);
         if (cnt == (ADDR_WIDTH+1)'(DEPTH-1)) state <= IDLE;
      end
   always_ff @(posedge clka)
      if (!rsta) begin
         if (busy) mem[cnt[ADDR_WIDTH-1:0]] <= '0;
         else if (acc)
            for (int i = 0; i < NB; i++)
               if (wea[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   // stage 2 only feeds the outputs when RD_LATENCY is 2
   always_ff @(posedge clka)
      if (rsta) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         d1 <= '0;
         d2 <= '0;
      end else begin
         v1 <= take;
         v2 <= v1;
         if (take) d1 <= (wr && WR_MODE == 1) ? merged : old;
         if (v1) d2 <= d1;
      end
   assign douta     = RD_LATENCY == 2 ? d2 : d1;
   assign douta_vld = RD_LATENCY == 2 ? v2 : v1;
endmodule

// File: tb/tb_sp_ram_ext.sv
// tb_sp_ram_ext: scoreboard bench over four sp_ram_ext variants sharing one stimulus stream
module tb_sp_ram_ext;
   typedef struct {int c; logic [31:0] d;} ent_t;
   logic        clk = 1'b0, rsta = 1'b1, ena = 1'b0;
   logic [3:0]  wea = '0;
   logic [9:0]  addra = '0;
   logic [31:0] dina = '0;
   logic [31:0] dout [4];
   logic        vld [4];
   logic        bsy [4];
   logic [31:0] rm [1024];
   ent_t        sq [4][$];
   ent_t        me;
   int          cyc = 0, n_cmp = 0, n_bad = 0, n;
   logic [31:0] held;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   sp_ram_ext u0 (.clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[0]), .douta_vld(vld[0]), .busy(bsy[0]));
   sp_ram_ext #(.WR_MODE(1)) u1 (.clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[1]), .douta_vld(vld[1]), .busy(bsy[1]));
   sp_ram_ext #(.WR_MODE(2)) u2 (.clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[2]), .douta_vld(vld[2]), .busy(bsy[2]));
   sp_ram_ext #(.RD_LATENCY(2)) u3 (.clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[3]), .douta_vld(vld[3]), .busy(bsy[3]));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one cycle of stimulus; live=1 means the bench expects the RAM to accept it
   task automatic drive(input logic e, input logic [3:0] w, input logic [9:0] a, input logic [31:0] d, input bit live);
      logic [31:0] o, m;
      @(negedge clk);
      ena = e; wea = w; addra = a; dina = d;
      if (e && live) begin
         o = rm[a];
         m = o;
         for (int i = 0; i < 4; i++) if (w[i]) m[i*8 +: 8] = d[i*8 +: 8];
         sq[0].push_back('{cyc + 1, o});
         sq[1].push_back('{cyc + 1, m});
         if (w == 4'h0) sq[2].push_back('{cyc + 1, o});
         sq[3].push_back('{cyc + 2, o});
         rm[a] = m;
      end
   endtask
   task automatic idle();
      drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b0);
   endtask
   always @(negedge clk)
      for (int k = 0; k < 4; k++)
         if (vld[k]) begin
            if (sq[k].size() == 0) chk($sformatf("unexpected_vld%0d", k), 32'd1, 32'd0);
            else begin
               me = sq[k].pop_front();
               chk($sformatf("vld_cycle%0d", k), cyc, me.c);
               chk($sformatf("data%0d", k), dout[k], me.d);
            end
         end else if (sq[k].size() > 0 && sq[k][0].c <= cyc) begin
            chk($sformatf("missing_vld%0d", k), 32'd0, 32'd1);
            void'(sq[k].pop_front());
         end
   initial begin
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_dout%0d", k), dout[k], 32'h0);
         chk($sformatf("rst_vld%0d", k), 32'(vld[k]), 32'd0);
         chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd1);
      end
      rsta = 1'b0;
      n = 0;
      while (bsy[0] && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 1024);
      for (int k = 0; k < 4; k++) chk($sformatf("busy_low%0d", k), 32'(bsy[k]), 32'd0);
      for (int i = 0; i < 1024; i++) rm[i] = '0;
      drive(1'b1, 4'h0, 10'h3FF, 32'h0, 1'b1);
      drive(1'b1, 4'hF, 10'h005, 32'hAABBCCDD, 1'b1);
      drive(1'b1, 4'b0101, 10'h005, 32'h11223344, 1'b1);
      drive(1'b1, 4'h0, 10'h005, 32'h0, 1'b1);
      idle();
      chk("merge_read", dout[0], 32'hAA22CC44);
      drive(1'b1, 4'hF, 10'h007, 32'h1, 1'b1);
      drive(1'b1, 4'h0, 10'h007, 32'h0, 1'b1);
      idle();
      held = dout[2];
      drive(1'b1, 4'hF, 10'h007, 32'h2, 1'b1);
      idle();
      chk("nochange_hold", dout[2], held);
      chk("nochange_vld", 32'(vld[2]), 32'd0);
      chk("read_first", dout[0], 32'h1);
      chk("write_first", dout[1], 32'h2);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, 10'(i), 32'hC0DE0000 + 32'(i), 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'h0, 10'(i), 32'h0, 1'b1);
      drive(1'b1, 4'hF, 10'h009, 32'h12345678, 1'b1);
      drive(1'b0, 4'hF, 10'h009, 32'hFFFFFFFF, 1'b1);
      drive(1'b1, 4'h0, 10'h009, 32'h0, 1'b1);
      repeat (150)
         drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
               10'($urandom_range(0, 15)), $urandom, 1'b1);
      repeat (3) idle();
      drive(1'b1, 4'h0, 10'h003, 32'h0, 1'b1);
      @(negedge clk);
      rsta = 1'b1; ena = 1'b0;
      sq[3].delete();
      repeat (2) @(negedge clk);
      chk("rst_discard", 32'(vld[3]), 32'd0);
      rsta = 1'b0;
      for (int i = 0; i < 500; i++) drive(1'b1, 4'hF, 10'(i), 32'hDEAD0000, 1'b0);
      rsta = 1'b1; ena = 1'b0;
      repeat (2) @(negedge clk);
      rsta = 1'b0;
      n = 0;
      while (bsy[0] && n < 3000) begin
         n++;
         drive(1'b1, 4'hF, 10'(n), 32'hBEEF0000, 1'b0);
      end
      ena = 1'b0;
      chk("busy_cycles_restart", n, 1024);
      for (int i = 0; i < 1024; i++) rm[i] = '0;
      for (int i = 0; i < 16; i++) drive(1'b1, 4'h0, 10'(i), 32'h0, 1'b1);
      drive(1'b1, 4'h0, 10'h3FF, 32'h0, 1'b1);
      repeat (4) idle();
      for (int k = 0; k < 4; k++) chk($sformatf("drain%0d", k), sq[k].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sp_ram_ext.md
SP_RAM_EXT -- requirements
Module: sp_ram_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; depth DEPTH = 2**ADDR_WIDTH words exactly.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, bits per write-enable lane; DATA_WIDTH SHALL be a multiple of it; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter WR_MODE, default 0, read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero whole array after reset.
REQ-007 clka  input  1  clock; all logic on rising edge.
REQ-008 rsta  input  1  reset; synchronous, active-high.
REQ-009 ena  input  1  port enable; access accepted when ena=1 and busy=0.
REQ-010 wea  input  NB  per-lane write enable; any bit set = write, all zero = read.
REQ-011 addra  input  ADDR_WIDTH  access address.
REQ-012 dina  input  DATA_WIDTH  write data; lane i = dina[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-013 douta  output  DATA_WIDTH  read data, registered.
REQ-014 douta_vld  output  1  one-cycle pulse marking new douta.
REQ-015 busy  output  1  array clear in progress; accesses ignored.

Function
REQ-016 Write: on accepted access with wea!=0, lanes with wea[i]=1 SHALL be updated at addra on that edge; other lanes unchanged.
REQ-017 Read: on accepted access with wea=0, mem[addra] SHALL appear on douta RD_LATENCY edges later, with douta_vld=1 for exactly that cycle.
REQ-018 Write with WR_MODE=0: douta SHALL present pre-write word at addra, douta_vld pulsed, same latency as read.
REQ-019 Write with WR_MODE=1: douta SHALL present merged post-write word (new lanes + untouched old lanes), douta_vld pulsed, same latency.
REQ-020 Write with WR_MODE=2: douta SHALL hold its value and douta_vld SHALL stay 0.
REQ-021 Cycles with ena=0 or busy=1 SHALL not modify memory, douta, or generate douta_vld; douta holds last value.
REQ-022 Pipeline SHALL accept one access per cycle without bubbles; RD_LATENCY=2 adds one output register stage, throughput unchanged.
REQ-023 Back-to-back write then read of same address SHALL return written data on the read.
REQ-024 FSM states: IDLE, CLEAR. CLEAR_ON_RESET=1: reset forces CLEAR with clear counter 0; CLEAR writes zero to address=counter each cycle, counter+1; after writing DEPTH-1 go to IDLE. CLEAR_ON_RESET=0: reset forces IDLE.
REQ-025 busy SHALL be 1 in CLEAR and 0 in IDLE; with CLEAR_ON_RESET=1 busy stays high for DEPTH cycles after first edge with rsta=0.
REQ-026 Clear counter SHALL be ADDR_WIDTH+1 bits or otherwise terminate without wrap; no address written twice per clear.

Reset
REQ-027 While rsta=1: douta=0, douta_vld=0, pipeline valid stages cleared, busy=CLEAR_ON_RESET, no memory writes.
REQ-028 rsta asserted mid-access or mid-clear SHALL discard in-flight reads (no douta_vld) and restart clear from address 0.
REQ-029 Memory contents SHALL be undefined after reset when CLEAR_ON_RESET=0.

Verification
REQ-030 Defaults, reset then release: busy=1 exactly 1024 cycles; then read addr 0x3FF -> douta=0x00000000, douta_vld one cycle after accept.
REQ-031 Write 0xAABBCCDD to 0x005 wea=4'b1111, then wea=4'b0101 dina=0x11223344 -> read returns 0xAA22CC44.
REQ-032 WR_MODE=0/1/2, mem[7]=0x1, write 0x2 to 7 -> douta 0x1 / 0x2 / unchanged with vld=0.
REQ-033 RD_LATENCY=2, reads of 0,1,2 on consecutive cycles -> data on cycles +2,+3,+4, vld high three consecutive cycles.
REQ-034 Assert rsta at clear counter 500 -> busy stays high 1024 cycles after release; writes attempted with busy=1 -> memory reads 0.
REQ-035 ena=0 with wea=4'hF, then ena=1 read same address -> old data returned, no vld during ena=0.
